// File: rtl/score_draw_pkg.sv
// Shared types and constants for the score drawing path: FSM states,
// sprite geometry, BCD codes and a decimal range helper.
package score_draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONVERT   = 3'd1,
        ST_RESET_DIG = 3'd2,
        ST_DRAW      = 3'd3,
        ST_NEXT      = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam int unsigned DIGIT_W = 32'd14;
    localparam int unsigned DIGIT_H = 32'd15;

    localparam logic [3:0] BCD_0 = 4'd0;
    localparam logic [3:0] BCD_1 = 4'd1;
    localparam logic [3:0] BCD_2 = 4'd2;
    localparam logic [3:0] BCD_3 = 4'd3;
    localparam logic [3:0] BCD_4 = 4'd4;
    localparam logic [3:0] BCD_5 = 4'd5;
    localparam logic [3:0] BCD_6 = 4'd6;
    localparam logic [3:0] BCD_7 = 4'd7;
    localparam logic [3:0] BCD_8 = 4'd8;
    localparam logic [3:0] BCD_9 = 4'd9;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 32'd1;
        for (int unsigned k = 32'd0; k < n; k++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_bcd_conv.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, the first
// folded into the load so the result is ready in the SCORE_W-th cycle.
module score_bcd_conv
    import score_draw_pkg::*;
#(
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned NUM_DIGITS = 4
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic [SCORE_W-1:0]        i_bin,
    output logic [4*NUM_DIGITS-1:0]   o_bcd,
    output logic                      o_done
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

    if (SCORE_W < 2) begin : g_bad_width
        $error("score_bcd_conv needs SCORE_W >= 2");
    end

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    logic [SCORE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic               r_done;
    logic [BCD_W-1:0]   w_adj;

    assign w_adj  = bcd_adjust(r_bcd);
    assign o_bcd  = r_bcd;
    assign o_done = r_done;

    // Load (first shift into an all-zero BCD needs no adjust) then iterate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin  <= {SCORE_W{1'b0}};
            r_bcd  <= {BCD_W{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bin <= {i_bin[SCORE_W-2:0], 1'b0};
                r_bcd <= {{(BCD_W-1){1'b0}}, i_bin[SCORE_W-1]};
                r_cnt <= CNT_W'(1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
                r_bcd <= {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_run  <= 1'b1;
                end
            end else begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/score_draw_ctrl.sv
// Score redraw sequencer: saturates and converts the score to BCD, then
// drives the single-digit drawer once per digit, most significant first.
module score_draw_ctrl
    import score_draw_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCORE_W     = 14,
    parameter logic [7:0]  X_ORIGIN    = 8'd100,
    parameter logic [7:0]  Y_ORIGIN    = 8'd4,
    parameter logic [7:0]  DIGIT_PITCH = 8'd14
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               scoreDrawStart,
    input  logic [SCORE_W-1:0] score,
    output logic               scoreDrawBusy,
    output logic               scoreDrawDone,
    output logic [3:0]         digitDrawSelect,
    output logic [7:0]         digitX,
    output logic [7:0]         digitY,
    output logic               digitDrawEnable,
    output logic               digitDrawReset,
    input  logic               digitDrawEnd
);

    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCD_W     = 4 * NUM_DIGITS;
    localparam int unsigned MAX_SCORE = pow10(NUM_DIGITS) - 32'd1;

    if (int'(X_ORIGIN) + (int'(NUM_DIGITS) - 1) * int'(DIGIT_PITCH) > 255) begin : g_bad_pos
        $error("last digit x position exceeds 255");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_conv_start;
    logic               w_conv_done;
    logic [SCORE_W-1:0] w_score_sat;
    logic [BCD_W-1:0]   w_bcd;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic [3:0]         w_sel;
    logic [7:0]         w_x;

    assign w_score_sat = (32'(score) > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : score;
    assign w_bcd_shift = w_bcd >> (32'd4 * (NUM_DIGITS - 32'd1 - 32'(w_next_idx)));

    score_bcd_conv #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_conv_start),
        .i_bin   (w_score_sat),
        .o_bcd   (w_bcd),
        .o_done  (w_conv_done)
    );

    // Next-state and digit index logic.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_conv_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (scoreDrawStart) begin
                    w_next_state = ST_CONVERT;
                    w_conv_start = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (w_conv_done) begin
                    w_next_state = ST_RESET_DIG;
                    w_next_idx   = {IDX_W{1'b0}};
                end else begin
                    w_next_state = ST_CONVERT;
                end
            end
            ST_RESET_DIG: w_next_state = ST_DRAW;
            ST_DRAW: begin
                if (digitDrawEnd) begin
                    w_next_state = ST_NEXT;
                end else begin
                    w_next_state = ST_DRAW;
                end
            end
            ST_NEXT: begin
                if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RESET_DIG;
                    w_next_idx   = r_idx + IDX_W'(1);
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Digit select and x are loaded on entry to RESET_DIG and held otherwise.
    always_comb begin
        w_sel = digitDrawSelect;
        w_x   = digitX;
        if (w_next_state == ST_RESET_DIG) begin
            w_sel = w_bcd_shift[3:0];
            w_x   = X_ORIGIN + 8'(w_next_idx) * DIGIT_PITCH;
        end else begin
            w_sel = digitDrawSelect;
            w_x   = digitX;
        end
    end

    // State register; outputs are registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_idx           <= {IDX_W{1'b0}};
            scoreDrawBusy   <= 1'b0;
            scoreDrawDone   <= 1'b0;
            digitDrawEnable <= 1'b0;
            digitDrawReset  <= 1'b1;
            digitDrawSelect <= BCD_0;
            digitX          <= X_ORIGIN;
            digitY          <= Y_ORIGIN;
        end else begin
            r_state         <= w_next_state;
            r_idx           <= w_next_idx;
            scoreDrawBusy   <= (w_next_state != ST_IDLE);
            scoreDrawDone   <= (w_next_state == ST_DONE);
            digitDrawEnable <= (w_next_state == ST_DRAW);
            digitDrawReset  <= (w_next_state != ST_DRAW) && (w_next_state != ST_NEXT);
            digitDrawSelect <= w_sel;
            digitX          <= w_x;
            digitY          <= Y_ORIGIN;
        end
    end

endmodule
